// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM
// with a ready-handshaked memory port and a retired-instruction counter.
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   opcode            : IR[6:0], stable from DECODE until back in FETCH
//   zero              : ALU zero flag for beq
//   mem_ready         : memory finishes the current access this cycle
//   pc_write, ir_write, iord, mem_read, mem_write, reg_write : enables/selects
//   mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source     : datapath muxes
//   instr_done, illegal_op : one-cycle retire / unsupported-opcode pulses
//   state             : current FSM state (debug)
//   instret           : retired-instruction count, wraps
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  state_t     cur, nxt;
  logic [6:0] op_q;
  logic       legal;
  logic       is_ld;

  // Raw enables before the reset mask.
  logic pcw_r, irw_r, mrd_r, mwr_r;
  logic rw_r, done_r, ill_r;

  assign is_ld = (op_q == OP_LW);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_R, OP_I,
      OP_BEQ, OP_JAL, OP_JALR: legal = 1'b1;
      default:                 legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= FETCH;
      op_q    <= '0;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) op_q <= opcode;
      if (done_r) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    nxt        = FETCH;
    pcw_r      = 1'b0;
    irw_r      = 1'b0;
    mrd_r      = 1'b0;
    mwr_r      = 1'b0;
    rw_r       = 1'b0;
    done_r     = 1'b0;
    ill_r      = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 1'b0;
    case (cur)
      FETCH: begin
        mrd_r     = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          irw_r = 1'b1;
          pcw_r = 1'b1;
          nxt   = DECODE;
        end else begin
          nxt = FETCH;
        end
      end
      DECODE: begin
        // ALUOut captures old_pc + imm as the branch/jal target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        if (legal) begin
          nxt = EXEC;
        end else begin
          ill_r = 1'b1;
          nxt   = FETCH;
        end
      end
      EXEC: begin
        case (op_q)
          OP_LW, OP_SW: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            nxt       = MEM;
          end
          OP_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            nxt       = WB;
          end
          OP_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            nxt       = WB;
          end
          OP_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_source = 1'b1;
            pcw_r     = zero;
            done_r    = 1'b1;
          end
          OP_JAL: begin
            // PC still holds old_pc + 4, which is the link value.
            pc_source  = 1'b1;
            pcw_r      = 1'b1;
            rw_r       = 1'b1;
            mem_to_reg = 2'b10;
            done_r     = 1'b1;
          end
          OP_JALR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b10;
            pcw_r      = 1'b1;
            rw_r       = 1'b1;
            mem_to_reg = 2'b10;
            done_r     = 1'b1;
          end
          default: nxt = FETCH;
        endcase
      end
      MEM: begin
        iord = 1'b1;
        if (is_ld) begin
          mrd_r = 1'b1;
          nxt   = mem_ready ? WB : MEM;
        end else begin
          mwr_r  = 1'b1;
          done_r = mem_ready;
          nxt    = mem_ready ? FETCH : MEM;
        end
      end
      WB: begin
        rw_r       = 1'b1;
        mem_to_reg = is_ld ? 2'b01 : 2'b00;
        done_r     = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  assign pc_write   = pcw_r  & ~reset;
  assign ir_write   = irw_r  & ~reset;
  assign mem_read   = mrd_r  & ~reset;
  assign mem_write  = mwr_r  & ~reset;
  assign reg_write  = rw_r   & ~reset;
  assign instr_done = done_r & ~reset;
  assign illegal_op = ill_r  & ~reset;
  assign state      = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: instruction-level expectation model
// compared against every output on every cycle, plus literal checks.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  typedef struct packed {
    logic [2:0]       st;
    logic             pcw;
    logic             irw;
    logic             iord;
    logic             mrd;
    logic             mwr;
    logic             rw;
    logic [1:0]       m2r;
    logic [1:0]       a;
    logic [1:0]       b;
    logic [1:0]       op;
    logic             pcs;
    logic             done;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, ir_write, iord, mem_read, mem_write;
  logic             reg_write, pc_source, instr_done, illegal_op;
  logic [1:0]       mem_to_reg, alu_src_a, alu_src_b, alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  int total = 0;
  int bad   = 0;
  exp_t expq[$];
  int   st_log[$];
  logic [CNT_W-1:0] m_cnt = '0;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e, g;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      g.st = state;      g.pcw = pc_write;  g.irw = ir_write;
      g.iord = iord;     g.mrd = mem_read;  g.mwr = mem_write;
      g.rw = reg_write;  g.m2r = mem_to_reg;
      g.a = alu_src_a;   g.b = alu_src_b;   g.op = alu_op;
      g.pcs = pc_source; g.done = instr_done; g.ill = illegal_op;
      g.cnt = instret;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL cycle t=%0t got=%h want=%h", $time, g, e);
      end
      st_log.push_back(int'(state));
    end
  end

  function automatic exp_t blank(input logic [2:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic rdy,
                     input logic [6:0] opc, input logic z,
                     input exp_t e);
    @(posedge clk);
    #1;
    reset = r;
    mem_ready = rdy;
    opcode = opc;
    zero = z;
    expq.push_back(e);
  endtask

  task automatic instr(input logic [6:0] opc, input logic z,
                       input int fw, input int mw, input bit abort);
    exp_t e;
    bit ld, sw, rr, ii, bq, jl, jr;
    ld = (opc == OP_LW);  sw = (opc == OP_SW);
    rr = (opc == OP_R);   ii = (opc == OP_I);
    bq = (opc == OP_BEQ); jl = (opc == OP_JAL);
    jr = (opc == OP_JALR);
    e = blank(3'd0);
    e.mrd = 1'b1;
    e.b = 2'd1;
    for (int k = 0; k < fw; k++) cyc(1'b0, 1'b0, opc, z, e);
    e.irw = 1'b1;
    e.pcw = 1'b1;
    cyc(1'b0, 1'b1, opc, z, e);
    e = blank(3'd1);
    e.a = 2'd1;
    e.b = 2'd2;
    if (!(ld || sw || rr || ii || bq || jl || jr)) begin
      e.ill = 1'b1;
      cyc(1'b0, 1'b0, opc, z, e);
      return;
    end
    cyc(1'b0, 1'b0, opc, z, e);
    e = blank(3'd2);
    if (bq || jl || jr) begin
      e.done = 1'b1;
      if (bq) begin
        e.a = 2'd2; e.op = 2'd1; e.pcs = 1'b1; e.pcw = z;
      end else if (jl) begin
        e.pcs = 1'b1; e.pcw = 1'b1; e.rw = 1'b1; e.m2r = 2'd2;
      end else begin
        e.a = 2'd2; e.b = 2'd2;
        e.pcw = 1'b1; e.rw = 1'b1; e.m2r = 2'd2;
      end
      cyc(1'b0, 1'b0, opc, z, e);
      m_cnt++;
      return;
    end
    e.a = 2'd2;
    if (rr || ii) begin
      e.b = rr ? 2'd0 : 2'd2;
      e.op = 2'd2;
      cyc(1'b0, 1'b0, opc, z, e);
    end else begin
      e.b = 2'd2;
      cyc(1'b0, 1'b0, opc, z, e);
      e = blank(3'd3);
      e.iord = 1'b1;
      e.mrd = ld;
      e.mwr = sw;
      for (int k = 0; k < mw; k++) cyc(1'b0, 1'b0, opc, z, e);
      if (abort) begin
        e.mrd = 1'b0;
        e.mwr = 1'b0;
        cyc(1'b1, 1'b0, opc, z, e);
        m_cnt = '0;
        return;
      end
      if (sw) begin
        e.done = 1'b1;
        cyc(1'b0, 1'b1, opc, z, e);
        m_cnt++;
        return;
      end
      cyc(1'b0, 1'b1, opc, z, e);
    end
    e = blank(3'd4);
    e.rw = 1'b1;
    e.m2r = ld ? 2'd1 : 2'd0;
    e.done = 1'b1;
    cyc(1'b0, 1'b0, opc, z, e);
    m_cnt++;
  endtask

  task automatic log_start();
    @(negedge clk);
    #1;
    st_log.delete();
  endtask

  task automatic chk_seq(input string nm, input logic [31:0] seq,
                         input int n);
    bit ok;
    @(negedge clk);
    #1;
    ok = (st_log.size() == n);
    for (int k = 0; k < n && ok; k++)
      if (st_log[k] != int'(seq[4*(n-1-k) +: 4])) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL seq %s got_len=%0d want=%h", nm, st_log.size(), seq);
    end
  endtask

  task automatic lit(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_R;
    zero = 1'b0;
    @(posedge clk);
    e = blank(3'd0);
    e.b = 2'd1;
    cyc(1'b1, 1'b1, OP_R, 1'b0, e);

    log_start();
    instr(OP_R, 1'b0, 0, 0, 1'b0);
    chk_seq("r_type", 32'h0124, 4);
    lit("cnt_after_r", int'(m_cnt), 1);

    log_start();
    instr(OP_LW, 1'b0, 0, 2, 1'b0);
    chk_seq("lw_wait2", 32'h0123334, 7);

    log_start();
    instr(OP_SW, 1'b0, 1, 0, 1'b0);
    chk_seq("sw_fwait", 32'h00123, 5);
    instr(OP_BEQ, 1'b1, 0, 0, 1'b0);
    instr(OP_BEQ, 1'b0, 0, 0, 1'b0);
    lit("cnt_after_br", int'(m_cnt), 5);

    instr(OP_I, 1'b0, 0, 0, 1'b0);

    log_start();
    instr(OP_JAL, 1'b0, 0, 0, 1'b0);
    chk_seq("jal", 32'h012, 3);
    log_start();
    instr(OP_JALR, 1'b1, 0, 0, 1'b0);
    chk_seq("jalr", 32'h012, 3);
    lit("cnt_after_j", int'(m_cnt), 8);

    log_start();
    instr(OP_BAD, 1'b0, 0, 0, 1'b0);
    chk_seq("illegal", 32'h01, 2);
    lit("cnt_after_ill", int'(m_cnt), 8);

    instr(OP_SW, 1'b0, 0, 1, 1'b0);
    instr(OP_LW, 1'b0, 0, 1, 1'b1);
    lit("cnt_after_abort", int'(m_cnt), 0);

    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0:       instr(OP_R, 1'b0, 0, 0, 1'b0);
        1:       instr(OP_I, 1'b0, 0, 0, 1'b0);
        2:       instr(OP_BEQ, k[3], 0, 0, 1'b0);
        default: instr(OP_JAL, 1'b0, 0, 0, 1'b0);
      endcase
    end
    lit("cnt_wrap", int'(m_cnt), 0);
    instr(OP_JALR, 1'b0, 0, 0, 1'b0);

    e = blank(3'd0);
    e.mrd = 1'b1;
    e.b = 2'd1;
    cyc(1'b0, 1'b0, OP_R, 1'b0, e);
    cyc(1'b0, 1'b0, OP_R, 1'b0, e);
    @(negedge clk);
    #1;
    lit("final_instret", int'(instret), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
